// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and sizing helpers for the sipo deserializer
package sipo_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit counter only has to reach WIDTH-1, so clog2 bits suffice (min 1).
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sipo_hold.sv
// rtl/sipo_hold.sv - parallel holding register with valid/ready and sticky overrun
module sipo_hold
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clr_i) begin
            // q is deliberately kept; only the handshake and flags drop.
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else if (load_i) begin
            if (!valid_q || ready_i) begin
                q_d     = data_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign q_o       = q_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - framed serial-in parallel-out deserializer top level
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sync,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             overrun,
    output logic             sync_err
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, bit_idx;
    logic [WIDTH-1:0] sr_q, sr_d, bit_mask, word;
    logic             serr_q, serr_d;
    logic             start, accept, complete;

    always_comb begin
        start    = sin_en && sync;
        accept   = start || (sin_en && (state_q == SHIFT));
        // A sync bit always restarts placement at bit 0, dropping any fragment.
        bit_idx  = start ? '0 : cnt_q;
        complete = accept && (bit_idx == LAST);

        if (LSB_FIRST)
            bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << bit_idx;
        else
            bit_mask = {1'b1, {(WIDTH-1){1'b0}}} >> bit_idx;

        word = ((start ? '0 : sr_q) & ~bit_mask) | (sin ? bit_mask : '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        serr_d  = serr_q;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
            serr_d  = 1'b0;
        end else if (accept) begin
            state_d = SHIFT;
            sr_d    = word;
            cnt_d   = complete ? '0 : bit_idx + CW'(1);
            if (start && (state_q == SHIFT) && (cnt_q != '0))
                serr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            serr_q  <= serr_d;
        end
    end

    sipo_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .load_i    (complete),
        .data_i    (word),
        .ready_i   (q_ready),
        .q_o       (q),
        .valid_o   (q_valid),
        .overrun_o (overrun)
    );

    assign busy     = (cnt_q != '0);
    assign sync_err = serr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - self-checking bench for sipo_deser, both bit orders
module tb_sipo_deser;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n, sin, sin_en, sync, clr, q_ready;
    logic [W-1:0] q_l, q_m;
    logic         qv_l, qv_m, busy_l, busy_m, ovr_l, ovr_m, serr_l, serr_m;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .sync(sync),
        .clr(clr), .q(q_l), .q_valid(qv_l), .q_ready(q_ready), .busy(busy_l),
        .overrun(ovr_l), .sync_err(serr_l)
    );

    sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .sync(sync),
        .clr(clr), .q(q_m), .q_valid(qv_m), .q_ready(q_ready), .busy(busy_m),
        .overrun(ovr_m), .sync_err(serr_m)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: accepted bits are collected in arrival order; a word is whatever
    // W bits have arrived since the last sync or word boundary.
    logic         m_bits[$];
    bit           m_in;
    logic [W-1:0] m_ql, m_qm;
    bit           m_valid, m_ovr, m_serr;

    function automatic void model_reset();
        m_bits.delete();
        m_in    = 1'b0;
        m_ql    = '0;
        m_qm    = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_serr  = 1'b0;
    endfunction

    function automatic void model_step(input logic s, en, sy, c, r);
        bit           done;
        logic [W-1:0] wl, wm;
        done = 1'b0;
        wl   = '0;
        wm   = '0;
        if (c) begin
            m_bits.delete();
            m_in    = 1'b0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_serr  = 1'b0;
        end else begin
            if (en && sy) begin
                if (m_in && m_bits.size() != 0) m_serr = 1'b1;
                m_bits.delete();
                m_bits.push_back(s);
                m_in = 1'b1;
            end else if (en && m_in) begin
                m_bits.push_back(s);
            end
            if (m_bits.size() == W) begin
                done = 1'b1;
                for (int k = 0; k < W; k++) begin
                    wl[k]       = m_bits[k];
                    wm[W-1-k]   = m_bits[k];
                end
                m_bits.delete();
            end
            if (done) begin
                if (!m_valid || r) begin
                    m_ql    = wl;
                    m_qm    = wm;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end
    endfunction

    always @(negedge clk) begin
        chk("q_lsb",      32'(q_l),    32'(m_ql));
        chk("q_msb",      32'(q_m),    32'(m_qm));
        chk("valid_lsb",  32'(qv_l),   32'(m_valid));
        chk("valid_msb",  32'(qv_m),   32'(m_valid));
        chk("busy_lsb",   32'(busy_l), 32'(m_bits.size() != 0));
        chk("busy_msb",   32'(busy_m), 32'(m_bits.size() != 0));
        chk("ovr_lsb",    32'(ovr_l),  32'(m_ovr));
        chk("ovr_msb",    32'(ovr_m),  32'(m_ovr));
        chk("serr_lsb",   32'(serr_l), 32'(m_serr));
        chk("serr_msb",   32'(serr_m), 32'(m_serr));
    end

    task automatic drive(input logic s, en, sy, c, r);
        sin     = s;
        sin_en  = en;
        sync    = sy;
        clr     = c;
        q_ready = r;
        @(posedge clk);
        model_step(s, en, sy, c, r);
        #1;
    endtask

    task automatic send(input logic [0:3] seq, input logic syn, input logic r, input int gap);
        for (int k = 0; k < 4; k++) begin
            drive(seq[k], 1'b1, syn && (k == 0), 1'b0, r);
            if (k < 3) repeat (gap) drive(1'b0, 1'b0, 1'b0, 1'b0, r);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q"},     32'({q_l, q_m}), 32'h0);
        chk({tag, "_flags"}, 32'({qv_l, qv_m, busy_l, busy_m, ovr_l, ovr_m, serr_l, serr_m}), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; sin = 1'b0; sin_en = 1'b0; sync = 1'b0; clr = 1'b0; q_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_all_zero("reset");

        // Basic framed word, consumer always ready
        send(4'b1011, 1'b1, 1'b1, 0);
        chk("t1_q_lsb", 32'(q_l), 32'hD);
        chk("t1_q_msb", 32'(q_m), 32'hB);
        chk("t1_valid", 32'(qv_l), 32'h1);
        chk("t1_model", 32'(m_ql), 32'hD);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_valid_1cyc", 32'(qv_l), 32'h0);

        // Unframed bits are ignored after clr returns to IDLE
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_busy", 32'(busy_l), 32'h0);
        chk("t2_valid", 32'(qv_l), 32'h0);
        send(4'b0110, 1'b1, 1'b1, 0);
        chk("t2_q", 32'(q_l), 32'h6);

        // Overrun with streaming second word
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(4'b1011, 1'b1, 1'b0, 0);
        send(4'b0110, 1'b0, 1'b0, 0);
        chk("t3_q_held", 32'(q_l), 32'hD);
        chk("t3_valid", 32'(qv_l), 32'h1);
        chk("t3_ovr", 32'(ovr_l), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_consumed", 32'(qv_l), 32'h0);
        chk("t3_ovr_sticky", 32'(ovr_l), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t3_ovr_clr", 32'(ovr_l), 32'h0);
        chk("t3_q_kept", 32'(q_l), 32'hD);

        // Resync mid-word
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_no_word", 32'(qv_l), 32'h0);
        send(4'b0110, 1'b1, 1'b1, 0);
        chk("t4_serr", 32'(serr_l), 32'h1);
        chk("t4_q", 32'(q_l), 32'h6);
        chk("t4_valid", 32'(qv_l), 32'h1);

        // MSB-first with gaps
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(4'b1011, 1'b1, 1'b1, 2);
        chk("t5_q_msb", 32'(q_m), 32'hB);
        chk("t5_q_lsb", 32'(q_l), 32'hD);

        // Asynchronous reset mid-word
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6_busy", 32'(busy_l), 32'h0);
        chk("t6_valid", 32'(qv_l), 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in parallel-out deserializer. It is the receive-side counterpart of the team's 4-bit PISO shifter. It collects a framed serial bit stream, one bit per enabled clock, into WIDTH-bit words. Each completed word is presented on a held parallel output with a valid/ready handshake, and overrun and resync errors are flagged. It sits between a serial link input and word-oriented consumer logic.

Parameters:
WIDTH, 4, word width in bits (>=2)
LSB_FIRST, 1, 1: first received bit lands in q[0]; 0: first bit lands in q[WIDTH-1]

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
sin  input  1  serial data bit
sin_en  input  1  sin is sampled on this edge when 1
sync  input  1  qualified by sin_en; marks the current bit as bit 0 of a word
clr  input  1  synchronous clear of FSM, counter, flags and q_valid
q  output  WIDTH  last completed word (holding register)
q_valid  output  1  q holds an unconsumed word
q_ready  input  1  consumer accepts q when q_valid && q_ready
busy  output  1  partial word in progress (bit count != 0)
overrun  output  1  sticky: a completed word was dropped
sync_err  output  1  sticky: sync arrived with a partial word in progress

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. Asserting rst_n clears immediately: state=IDLE, count=0, shift register=0, q=0, q_valid=0, overrun=0, sync_err=0, busy=0. All logic runs in one clock domain.
- FSM states:
  - IDLE: bits with sin_en=1 and sync=0 are ignored. sin_en=1 with sync=1 accepts the bit as bit 0, sets count=1 and moves to SHIFT.
  - SHIFT: each sin_en=1 edge accepts one bit and increments count. Cycles with sin_en=0 hold all state; gaps of any length are legal.
- Bit placement: the k-th accepted bit (k=0..WIDTH-1) goes to q[k] when LSB_FIRST=1, otherwise to q[WIDTH-1-k].
- Word completion happens on the edge that accepts bit WIDTH-1:
  - The assembled word transfers to the holding register and count wraps to 0.
  - The FSM stays in SHIFT, so streaming continues without a new sync.
  - q and q_valid update on that edge. Latency is 1 cycle from the last bit being presented to q_valid=1.
- Handshake:
  - q_valid && q_ready at an edge consumes the word; q_valid falls unless a new word completes on the same edge.
  - Word completes with q_valid=0, or with q_valid=1 and q_ready=1: the new word loads and q_valid=1.
  - Word completes with q_valid=1 and q_ready=0: the new word is discarded, q is unchanged, and overrun is set to 1.
  - q never changes while q_valid=1 and q_ready=0.
- Resync: sync=1 with sin_en=1 in SHIFT while count!=0 discards the partial word, sets sync_err=1 and restarts with this bit as bit 0 (count=1). The same sync with count=0 is a legal aligned word start, and no error is raised.
- busy = (count != 0).
- clr=1 at an edge:
  - Sets state=IDLE, count=0, q_valid=0, overrun=0, sync_err=0. q keeps its value.
  - clr has priority over any simultaneous sin_en, sync or handshake.
- Rising edge of rst_n mid-word: the partial word is lost. The FSM then requires a fresh sync.
- count width is clog2(WIDTH). Wrap from WIDTH-1 to 0 is explicit and never overflows the register.

Decomposition:
- Shared package sipo_pkg holds:
  - state enum typedef {IDLE, SHIFT}
  - a counter-width constant/function derived from WIDTH
- One sub-module, sipo_hold: the WIDTH-bit holding register with the valid/ready and overrun logic. The top level keeps the FSM, bit counter and shift/placement logic.

Test Plan:
- Reset; sync+bits 1,0,1,1 on 4 consecutive sin_en cycles, q_ready=1 -> q=4'hD, q_valid=1 for exactly 1 cycle starting the edge after bit 3; busy 1 during bits 1..3; flags 0.
- After reset, 3 bits with sin_en=1 and sync=0 -> count stays 0, busy=0, q_valid=0; the next sync-framed word 0,1,1,0 -> q=4'h6.
- q_ready=0; stream words 1,0,1,1 then 0,1,1,0 with no second sync -> q=4'hD held, q_valid=1, overrun=1 after word 2; q_ready=1 for 1 cycle -> q_valid=0, overrun stays 1; clr -> overrun=0.
- Sync, bits 1,1, then sync again with bits 0,1,1,0 -> sync_err=1, q=4'h6, no word emitted for the aborted fragment.
- LSB_FIRST=0, bits 1,0,1,1 with 2 idle cycles between each -> q=4'hB; gaps do not change count.
- rst_n low asynchronously after 2 bits -> all outputs 0 in the same cycle; after release, bits without sync are ignored.
